// File: rtl/snn_tick_sequencer_if.sv
// Grid-side and packet/count-memory signals of the SNN tick sequencer.
// The master modport is the sequencer; the slave modport is the grid plus memories.
interface snn_tick_sequencer_if #(
  parameter int PACKET_W = 30,
  parameter int ADDR_W   = 21,
  parameter int CNT_W    = 11,
  parameter int PIC_W    = 16
);
  logic [PIC_W-1:0]    cnt_mem_addr;
  logic [CNT_W-1:0]    cnt_mem_data;
  logic [ADDR_W-1:0]   pkt_mem_addr;
  logic [PACKET_W-1:0] pkt_mem_data;
  logic                tick;
  logic                input_buffer_empty;
  logic [PACKET_W-1:0] packet_in;
  logic                ren_to_input_buffer;
  logic [7:0]          packet_out;
  logic                packet_out_valid;
  logic                grid_error;

  modport master (
    output cnt_mem_addr, pkt_mem_addr, tick, input_buffer_empty, packet_in,
    input  cnt_mem_data, pkt_mem_data, ren_to_input_buffer, packet_out, packet_out_valid, grid_error
  );

  modport slave (
    input  cnt_mem_addr, pkt_mem_addr, tick, input_buffer_empty, packet_in,
    output cnt_mem_data, pkt_mem_data, ren_to_input_buffer, packet_out, packet_out_valid, grid_error
  );
endinterface

// File: rtl/snn_tick_sequencer.sv
// Tick/frame controller for a layered SNN grid: issues periodic ticks, streams each picture's
// packets from memory into the grid and gathers output spikes into one vector per picture.
module snn_tick_sequencer #(
  parameter int PACKET_W    = 30,
  parameter int NUM_OUTPUT  = 250,
  parameter int ADDR_W      = 21,
  parameter int CNT_W       = 11,
  parameter int PIC_W       = 16,
  parameter int NUM_LAYERS  = 2,
  parameter int INIT_CYCLES = 4000,
  parameter int TICK_PERIOD = 1005
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [PIC_W-1:0]      num_picture,
  snn_tick_sequencer_if.master  bus,
  output logic [NUM_OUTPUT-1:0] spike_vec,
  output logic                  spike_vec_valid,
  output logic [PIC_W-1:0]      spike_vec_idx,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);
  localparam int PER_W  = $clog2(TICK_PERIOD);
  localparam int INIT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam int WIN_W  = PIC_W + 2;

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_TICK, S_LOADCNT, S_FEED, S_WAIT, S_DONE
  } state_t;

  state_t                state, state_nxt;
  logic [PIC_W-1:0]      num_pic;
  logic [WIN_W-1:0]      win, num_pic_w, last_win, win_inc, strobe_pic;
  logic [INIT_W-1:0]     init_cnt;
  logic [PER_W-1:0]      per_cnt;
  logic [CNT_W-1:0]      remaining;
  logic [NUM_OUTPUT-1:0] acc, spike_onehot;
  logic [31:0]           spike_sh;
  logic                  spike_hit, accept, per_expire, consume, overrun, strobe_en;

  assign accept     = (state == S_IDLE) && start;
  assign num_pic_w  = WIN_W'(num_pic);
  assign last_win   = num_pic_w + WIN_W'(NUM_LAYERS - 1);
  assign win_inc    = win + WIN_W'(1);
  assign strobe_pic = win - WIN_W'(NUM_LAYERS);
  assign strobe_en  = (win >= WIN_W'(NUM_LAYERS)) && (strobe_pic < num_pic_w);
  assign per_expire = (per_cnt == PER_W'(TICK_PERIOD - 1));
  assign consume    = (state == S_FEED) && bus.ren_to_input_buffer && !bus.input_buffer_empty
                      && (remaining != '0);
  // A packet taken on the expiring edge that empties the picture is not an overrun.
  assign overrun    = (state == S_FEED) && per_expire && (remaining != '0)
                      && !(consume && (remaining == CNT_W'(1)));

  assign bus.tick = (state == S_TICK);
  assign done     = (state == S_DONE);
  assign busy     = (state != S_IDLE) && (state != S_DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (start) state_nxt = (num_picture == '0) ? S_DONE : S_INIT;
      S_INIT:    if (init_cnt == INIT_W'(INIT_CYCLES - 1)) state_nxt = S_TICK;
      S_TICK: begin
        if (win == last_win)       state_nxt = S_DONE;
        else if (win < num_pic_w)  state_nxt = S_LOADCNT;
        else                       state_nxt = S_WAIT;
      end
      S_LOADCNT: state_nxt = (bus.cnt_mem_data == '0) ? S_WAIT : S_FEED;
      S_FEED: begin
        if (per_expire)                                  state_nxt = S_TICK;
        else if (consume && (remaining == CNT_W'(1)))    state_nxt = S_WAIT;
      end
      S_WAIT:    if (per_expire) state_nxt = S_TICK;
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Control: state, window/period counters, count-memory address, sticky error
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= S_IDLE;
      num_pic          <= '0;
      win              <= '0;
      init_cnt         <= '0;
      per_cnt          <= '0;
      bus.cnt_mem_addr <= '0;
      error            <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        num_pic          <= num_picture;
        win              <= '0;
        init_cnt         <= '0;
        bus.cnt_mem_addr <= '0;
      end
      if (state == S_INIT) init_cnt <= init_cnt + INIT_W'(1);
      if (state == S_TICK) begin
        win     <= win_inc;
        per_cnt <= PER_W'(1);
        if (win_inc < num_pic_w) bus.cnt_mem_addr <= PIC_W'(win_inc);
      end else if ((state == S_LOADCNT) || (state == S_FEED) || (state == S_WAIT)) begin
        per_cnt <= per_cnt + PER_W'(1);
      end else begin
        per_cnt <= '0;
      end
      if (accept)                                 error <= 1'b0;
      else if (overrun || (busy && bus.grid_error)) error <= 1'b1;
    end
  end

  // Feed: packet address, remaining count, buffer-empty flag and the presented packet
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.pkt_mem_addr       <= '0;
      remaining              <= '0;
      bus.input_buffer_empty <= 1'b1;
      bus.packet_in          <= '0;
    end else begin
      if (consume) bus.packet_in <= bus.pkt_mem_data;
      if (accept) begin
        bus.pkt_mem_addr       <= '0;
        remaining              <= '0;
        bus.input_buffer_empty <= 1'b1;
      end else if (state == S_LOADCNT) begin
        remaining              <= bus.cnt_mem_data;
        bus.input_buffer_empty <= (bus.cnt_mem_data == '0);
      end else if (state == S_FEED) begin
        if (per_expire) begin
          // Skip unsent packets so the next picture starts at its own base address.
          bus.pkt_mem_addr       <= bus.pkt_mem_addr + ADDR_W'(remaining);
          remaining              <= '0;
          bus.input_buffer_empty <= 1'b1;
        end else if (consume) begin
          bus.pkt_mem_addr <= bus.pkt_mem_addr + ADDR_W'(1);
          remaining        <= remaining - CNT_W'(1);
          if (remaining == CNT_W'(1)) bus.input_buffer_empty <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    spike_sh     = 32'(NUM_OUTPUT - 1) - {24'd0, bus.packet_out};
    spike_hit    = bus.packet_out_valid && ({24'd0, bus.packet_out} < 32'(NUM_OUTPUT));
    spike_onehot = spike_hit ? (NUM_OUTPUT'(1) << spike_sh) : '0;
  end

  // Capture: per-window accumulator, handed off as a picture result on each tick
  always_ff @(posedge clk) begin
    if (reset) begin
      acc             <= '0;
      spike_vec       <= '0;
      spike_vec_idx   <= '0;
      spike_vec_valid <= 1'b0;
    end else begin
      spike_vec_valid <= 1'b0;
      if (accept) begin
        acc <= '0;
      end else if (state == S_TICK) begin
        acc <= spike_onehot;
        if (strobe_en) begin
          spike_vec       <= acc;
          spike_vec_idx   <= PIC_W'(strobe_pic);
          spike_vec_valid <= 1'b1;
        end
      end else begin
        acc <= acc | spike_onehot;
      end
    end
  end
endmodule

// File: tb/tb_snn_tick_sequencer.sv
// Bench for snn_tick_sequencer: directed runs plus randomized runs, each compared cycle by
// cycle against a window/offset reference model of the tick, feed and capture rules.
module tb_snn_tick_sequencer;
  localparam int PW = 30, NO = 250, AW = 21, CW = 11, PICW = 16;
  localparam int NL = 2, I = 10, P = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset, start;
  logic [PICW-1:0] num_picture;
  logic [NO-1:0]   spike_vec;
  logic            spike_vec_valid;
  logic [PICW-1:0] spike_vec_idx;
  logic            busy, done, error;

  snn_tick_sequencer_if #(.PACKET_W(PW), .ADDR_W(AW), .CNT_W(CW), .PIC_W(PICW)) bus ();

  snn_tick_sequencer #(
    .PACKET_W(PW), .NUM_OUTPUT(NO), .ADDR_W(AW), .CNT_W(CW), .PIC_W(PICW),
    .NUM_LAYERS(NL), .INIT_CYCLES(I), .TICK_PERIOD(P)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .num_picture(num_picture), .bus(bus),
    .spike_vec(spike_vec), .spike_vec_valid(spike_vec_valid), .spike_vec_idx(spike_vec_idx),
    .busy(busy), .done(done), .error(error)
  );

  logic [CW-1:0] cnt_mem [0:63];
  logic [PW-1:0] pkt_mem [0:1023];
  always_ff @(posedge clk) bus.cnt_mem_data <= cnt_mem[bus.cnt_mem_addr[5:0]];
  assign bus.pkt_mem_data = pkt_mem[bus.pkt_mem_addr[9:0]];

  int n_chk = 0, n_pass = 0;
  logic [PW-1:0] m_pkt;

  task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  task automatic drive_idle();
    start = 1'b0;
    bus.ren_to_input_buffer = 1'b0;
    bus.packet_out_valid = 1'b0;
    bus.packet_out = 8'd0;
    bus.grid_error = 1'b0;
  endtask

  // ren_mode: 0 always 1, 1 toggling, 2 random. spk_mode: 0 none, 1 directed, 2 random, 3 out-of-range.
  task automatic run_case(input string nm, input int n, input int ren_mode, input int spk_mode,
                          input bit mid_start, input int rst_at, input bit gerr_en);
    int done_c, w, k, t, p, m_rem;
    logic [AW-1:0] m_addr;
    bit m_ibe, m_err, rv, pv, gv, st, e_tick, e_valid;
    logic [7:0] pidx;
    logic [NO-1:0] exp_vec [0:15];
    for (int i = 0; i < 16; i++) exp_vec[i] = '0;
    done_c = (n == 0) ? 0 : I + (n + NL - 1) * P + 1;
    m_addr = '0; m_rem = 0; m_ibe = 1'b1; m_err = 1'b0;
    @(negedge clk);
    start = 1'b1;
    num_picture = PICW'(n);
    for (int c = 0; c <= done_c + 1; c++) begin
      @(negedge clk);
      e_tick = (c >= I) && ((c - I) % P == 0) && ((c - I) / P < n + NL);
      e_valid = 1'b0;
      p = -1;
      if (c >= I + 1 && ((c - I - 1) % P == 0)) begin
        t = (c - I - 1) / P;
        p = t - NL;
        e_valid = (p >= 0) && (p < n);
      end
      chk($sformatf("%s.tick@%0d", nm, c), 256'(bus.tick), 256'(e_tick));
      chk($sformatf("%s.busy@%0d", nm, c), 256'(busy), 256'(c < done_c));
      chk($sformatf("%s.done@%0d", nm, c), 256'(done), 256'(c == done_c));
      chk($sformatf("%s.ibe@%0d", nm, c), 256'(bus.input_buffer_empty), 256'(m_ibe));
      chk($sformatf("%s.addr@%0d", nm, c), 256'(bus.pkt_mem_addr), 256'(m_addr));
      chk($sformatf("%s.pkt@%0d", nm, c), 256'(bus.packet_in), 256'(m_pkt));
      chk($sformatf("%s.err@%0d", nm, c), 256'(error), 256'(m_err));
      chk($sformatf("%s.svv@%0d", nm, c), 256'(spike_vec_valid), 256'(e_valid));
      if (e_valid) begin
        chk($sformatf("%s.svec%0d", nm, p), 256'(spike_vec), 256'(exp_vec[p]));
        chk($sformatf("%s.sidx%0d", nm, p), 256'(spike_vec_idx), 256'(p));
      end
      if (c == rst_at) begin
        drive_idle();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_pkt = '0;
        chk({nm, ".rst.busy"}, 256'(busy), 256'(0));
        chk({nm, ".rst.done"}, 256'(done), 256'(0));
        chk({nm, ".rst.ibe"}, 256'(bus.input_buffer_empty), 256'(1));
        chk({nm, ".rst.tick"}, 256'(bus.tick), 256'(0));
        chk({nm, ".rst.addr"}, 256'(bus.pkt_mem_addr), 256'(0));
        chk({nm, ".rst.pkt"}, 256'(bus.packet_in), 256'(0));
        return;
      end
      // stimulus for the coming edge
      case (ren_mode)
        0:       rv = 1'b1;
        1:       rv = (c % 2 == 1);
        default: rv = 1'($urandom_range(0, 1));
      endcase
      pv = 1'b0;
      pidx = 8'($urandom_range(0, 255));
      if (spk_mode == 1) begin
        if (c == I + P + 5)     begin pv = 1'b1; pidx = 8'd0;   end
        if (c == I + 2 * P + 5) begin pv = 1'b1; pidx = 8'd249; end
        if (c == I + 3 * P + 5) begin pv = 1'b1; pidx = 8'd7;   end
      end else if (spk_mode == 2) begin
        pv = ($urandom_range(0, 7) == 0);
      end else if (spk_mode == 3) begin
        if (c == I + P + 5) begin pv = 1'b1; pidx = 8'd250; end
        if (c == I + P + 7) begin pv = 1'b1; pidx = 8'd3;   end
      end
      gv = gerr_en && ($urandom_range(0, 99) == 0);
      st = mid_start && (c == I + P + 3);
      // reference model: window w, cycle offset k within the window
      if (c >= I) begin
        w = (c - I) / P;
        k = (c - I) % P;
        if (w < n) begin
          if (k == 1) begin
            m_rem = int'(cnt_mem[w]);
            m_ibe = (m_rem == 0);
          end else if (k >= 2) begin
            if (rv && m_rem > 0) begin
              m_pkt = pkt_mem[m_addr[9:0]];
              m_addr = m_addr + AW'(1);
              m_rem--;
              if (m_rem == 0) m_ibe = 1'b1;
            end
            if (k == P - 1 && m_rem > 0) begin
              m_err = 1'b1;
              m_addr = m_addr + AW'(m_rem);
              m_rem = 0;
              m_ibe = 1'b1;
            end
          end
        end
        if (w < n + NL && pv && pidx < 8'(NO)) begin
          p = w - NL + 1;
          if (p >= 0 && p < n) exp_vec[p][NO - 1 - int'(pidx)] = 1'b1;
        end
      end
      if (c < done_c && gv) m_err = 1'b1;
      bus.ren_to_input_buffer = rv;
      bus.packet_out_valid = pv;
      bus.packet_out = pidx;
      bus.grid_error = gv;
      start = st;
      if (st) num_picture = PICW'(7);
    end
    drive_idle();
  endtask

  initial begin
    reset = 1'b1;
    num_picture = '0;
    drive_idle();
    m_pkt = '0;
    for (int i = 0; i < 1024; i++) pkt_mem[i] = PW'($urandom);
    for (int i = 0; i < 64; i++) cnt_mem[i] = '0;
    repeat (3) @(negedge clk);
    chk("reset.tick", 256'(bus.tick), 256'(0));
    chk("reset.ibe", 256'(bus.input_buffer_empty), 256'(1));
    chk("reset.busy", 256'(busy), 256'(0));
    chk("reset.done", 256'(done), 256'(0));
    chk("reset.err", 256'(error), 256'(0));
    chk("reset.svv", 256'(spike_vec_valid), 256'(0));
    chk("reset.svec", 256'(spike_vec), 256'(0));
    chk("reset.pkt", 256'(bus.packet_in), 256'(0));
    chk("reset.addr", 256'(bus.pkt_mem_addr), 256'(0));
    reset = 1'b0;

    cnt_mem[0] = CW'(2); cnt_mem[1] = CW'(0); cnt_mem[2] = CW'(5);
    run_case("basic", 3, 0, 1, 1'b0, -1, 1'b0);

    cnt_mem[0] = CW'(30); cnt_mem[1] = CW'(3);
    run_case("overrun", 2, 0, 2, 1'b0, -1, 1'b0);

    cnt_mem[0] = CW'(1); cnt_mem[1] = CW'(4); cnt_mem[2] = CW'(2);
    run_case("midstart", 3, 2, 0, 1'b1, -1, 1'b0);
    run_case("zero", 0, 0, 0, 1'b0, -1, 1'b0);

    cnt_mem[0] = CW'(10); cnt_mem[1] = CW'(2);
    run_case("rstfeed", 2, 0, 0, 1'b0, I + 4, 1'b0);
    run_case("afterrst", 2, 0, 0, 1'b0, -1, 1'b0);

    cnt_mem[0] = CW'(4); cnt_mem[1] = CW'(4);
    run_case("toggle", 2, 1, 3, 1'b0, -1, 1'b0);

    for (int r = 0; r < 8; r++) begin
      int nn;
      nn = $urandom_range(1, 6);
      for (int i = 0; i < nn; i++) cnt_mem[i] = CW'($urandom_range(0, 22));
      run_case($sformatf("rnd%0d", r), nn, 2, 2, 1'b0, -1, r >= 5);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
